sparse_weight_packer: RTL and testbench

Write-side encoder for the sparse weight memory: consumes a dense, signed weight stream over a valid/ready handshake and discards zero (or pruned) values. Each surviving weight is written as one packed {index, value} word to a BRAM write port, with index = dense position within the current tensor. A completion pulse reports the non-zero count. It sits between the quantize/prune stage and the weight BRAM that the sparse inference datapath later reads.

---
 rtl/sparse_weight_packer.sv | 181 ++++++++++++++++++
 tb/tb_sparse_weight_packer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_weight_packer.sv
// sparse_weight_packer: write-side encoder for the sparse weight memory.
// Accepts a dense signed weight stream and drops the zero or pruned values.
// Each surviving weight is written to the BRAM port as one {index, value} word,
// where index is the element's dense position within the current tensor.
//
// Handshake: an element transfers on a rising edge where in_valid && in_ready.
// in_ready is high for the whole RUN state and low in IDLE. No other
// backpressure is applied.
//
// Optional feature macro: SPARSE_PACK_THRESH_EN. When it is defined, the
// thresh port exists and an element is kept iff |in_data| > thresh.
// Without it, an element is kept iff in_data != 0.
module sparse_weight_packer #(
    parameter int DEPTH       = 1024,
    parameter int INDEX_WIDTH = 12,
    parameter int VALUE_WIDTH = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [VALUE_WIDTH-1:0]             in_data,
    input  logic                               in_last,
`ifdef SPARSE_PACK_THRESH_EN
    input  logic [VALUE_WIDTH-1:0]             thresh,
`endif
    output logic                               wr_en,
    output logic [$clog2(DEPTH)-1:0]           wr_addr,
    output logic [INDEX_WIDTH+VALUE_WIDTH-1:0] wr_data,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(DEPTH):0]             nnz_count,
    output logic                               overflow,
    output logic                               idx_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = INDEX_WIDTH;
    localparam int VW = VALUE_WIDTH;

    localparam logic [CW-1:0] NNZ_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] NNZ_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [IW:0]   IDX_ONE  = {{IW{1'b0}}, 1'b1};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic                 in_ready_q, in_ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 wr_en_q, wr_en_d;
    logic [AW-1:0]        wr_addr_q, wr_addr_d;
    logic [IW+VW-1:0]     wr_data_q, wr_data_d;
    logic [CW-1:0]        nnz_q, nnz_d;
    logic                 overflow_q, overflow_d;
    logic                 idx_err_q, idx_err_d;
    // The extra MSB marks that the dense index has run past 2^IW-1.
    // The counter saturates there, so the error condition stays visible.
    logic [IW:0]          idx_q, idx_d;

    logic                 keep;

`ifdef SPARSE_PACK_THRESH_EN
    logic [VW-1:0]        magnitude;
    // Magnitude as an unsigned VW-bit value, so the most negative input maps to 2^(VW-1).
    always_comb begin
        magnitude = in_data[VW-1] ? (~in_data + {{(VW-1){1'b0}}, 1'b1}) : in_data;
        keep      = (magnitude > thresh);
    end
`else
    // Keep every non-zero weight.
    always_comb begin
        keep = (in_data != '0);
    end
`endif

    // Next-state and next-output logic for the IDLE/RUN controller.
    always_comb begin
        state_d    = state_q;
        in_ready_d = in_ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        nnz_d      = nnz_q;
        overflow_d = overflow_q;
        idx_err_d  = idx_err_q;
        idx_d      = idx_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b1;
                    nnz_d      = '0;
                    overflow_d = 1'b0;
                    idx_err_d  = 1'b0;
                    idx_d      = '0;
                end
            end
            RUN: begin
                if (in_valid) begin
                    if (idx_q[IW]) begin
                        // No representable index is left, so drop the element.
                        idx_err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                        if (keep) begin
                            if (nnz_q < NNZ_FULL) begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = nnz_q[AW-1:0];
                                wr_data_d = {idx_q[IW-1:0], in_data};
                                nnz_d     = nnz_q + NNZ_ONE;
                            end else begin
                                overflow_d = 1'b1;
                            end
                        end
                    end
                    if (in_last) begin
                        state_d    = IDLE;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // Register the state and all outputs. Reset is asynchronous and clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            nnz_q      <= '0;
            overflow_q <= 1'b0;
            idx_err_q  <= 1'b0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            nnz_q      <= nnz_d;
            overflow_q <= overflow_d;
            idx_err_q  <= idx_err_d;
            idx_q      <= idx_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign nnz_count = nnz_q;
    assign overflow  = overflow_q;
    assign idx_err   = idx_err_q;

endmodule

// File: tb/tb_sparse_weight_packer.sv
// Testbench for sparse_weight_packer using directed vectors.
// Two instances share the same stimulus:
//   u_a: DEPTH=4,  INDEX_WIDTH=12 (exercises memory overflow)
//   u_b: DEPTH=16, INDEX_WIDTH=3  (exercises index wrap)
module tb_sparse_weight_packer;

    // Clock and reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start    = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last  = 1'b0;
    logic [15:0] in_data  = 16'h0;
    logic [15:0] thresh   = 16'h0;

    logic        a_in_ready, a_wr_en, a_busy, a_done, a_ov, a_ie;
    logic [1:0]  a_wr_addr;
    logic [27:0] a_wr_data;
    logic [2:0]  a_nnz;

    logic        b_in_ready, b_wr_en, b_busy, b_done, b_ov, b_ie;
    logic [3:0]  b_wr_addr;
    logic [18:0] b_wr_data;
    logic [4:0]  b_nnz;

    sparse_weight_packer #(.DEPTH(4), .INDEX_WIDTH(12), .VALUE_WIDTH(16)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(a_in_ready), .in_data(in_data), .in_last(in_last),
`ifdef SPARSE_PACK_THRESH_EN
        .thresh(thresh),
`endif
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .busy(a_busy), .done(a_done), .nnz_count(a_nnz),
        .overflow(a_ov), .idx_err(a_ie)
    );

    sparse_weight_packer #(.DEPTH(16), .INDEX_WIDTH(3), .VALUE_WIDTH(16)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(b_in_ready), .in_data(in_data), .in_last(in_last),
`ifdef SPARSE_PACK_THRESH_EN
        .thresh(thresh),
`endif
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .busy(b_busy), .done(b_done), .nnz_count(b_nnz),
        .overflow(b_ov), .idx_err(b_ie)
    );

    // Scoreboard
    logic [63:0] exp_a_q[$];
    logic [63:0] exp_b_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Hand-built expected words: {addr, index, value}.
    function automatic logic [63:0] pk_a(input int addr, input int idx, input logic [15:0] v);
        return {34'd0, addr[1:0], idx[11:0], v};
    endfunction

    function automatic logic [63:0] pk_b(input int addr, input int idx, input logic [15:0] v);
        return {41'd0, addr[3:0], idx[2:0], v};
    endfunction

    // Write monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n && a_wr_en) begin
            if (exp_a_q.size() == 0) check("a_wr_unexpected", 64'({a_wr_addr, a_wr_data}), 64'hdead);
            else check("a_wr", 64'({a_wr_addr, a_wr_data}), exp_a_q.pop_front());
        end
        if (rst_n && b_wr_en) begin
            if (exp_b_q.size() == 0) check("b_wr_unexpected", 64'({b_wr_addr, b_wr_data}), 64'hdead);
            else check("b_wr", 64'({b_wr_addr, b_wr_data}), exp_b_q.pop_front());
        end
    end

    // Driver tasks
    task automatic check_zero(input string tag);
        check({tag, "_a_all_zero"}, 64'({a_wr_en, a_wr_addr, a_wr_data, a_nnz, a_ov, a_ie,
                                          a_done, a_busy, a_in_ready}), 64'd0);
        check({tag, "_b_all_zero"}, 64'({b_wr_en, b_wr_addr, b_wr_data, b_nnz, b_ov, b_ie,
                                          b_done, b_busy, b_in_ready}), 64'd0);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("a_in_ready_start", 64'(a_in_ready), 64'd1);
        check("b_busy_start", 64'(b_busy), 64'd1);
        check("a_flags_cleared", 64'({a_nnz, a_ov, a_ie}), 64'd0);
        check("b_flags_cleared", 64'({b_nnz, b_ov, b_ie}), 64'd0);
    endtask

    task automatic send(input logic [15:0] d, input logic last);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        #1;
        if (last) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    // Call right after the last element is sent: done, count and flags are checked in the following cycle.
    task automatic check_end(input int na, input int oa, input int ia,
                             input int nb, input int ob, input int ib);
        check("a_done", 64'(a_done), 64'd1);
        check("b_done", 64'(b_done), 64'd1);
        check("a_rdy_busy_end", 64'({a_in_ready, a_busy}), 64'd0);
        check("b_rdy_busy_end", 64'({b_in_ready, b_busy}), 64'd0);
        check("a_nnz", 64'(a_nnz), 64'(na));
        check("a_overflow", 64'(a_ov), 64'(oa));
        check("a_idx_err", 64'(a_ie), 64'(ia));
        check("b_nnz", 64'(b_nnz), 64'(nb));
        check("b_overflow", 64'(b_ov), 64'(ob));
        check("b_idx_err", 64'(b_ie), 64'(ib));
        @(posedge clk);
        #1;
        check("a_done_pulse", 64'(a_done), 64'd0);
        check("b_done_pulse", 64'(b_done), 64'd0);
        check("a_exp_left", 64'(exp_a_q.size()), 64'd0);
        check("b_exp_left", 64'(exp_b_q.size()), 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Sparse stream 0,5,0,0,-3,7
        do_start();
        exp_a_q.push_back(pk_a(0, 1, 16'h0005));
        exp_a_q.push_back(pk_a(1, 4, 16'hFFFD));
        exp_a_q.push_back(pk_a(2, 5, 16'h0007));
        exp_b_q.push_back(pk_b(0, 1, 16'h0005));
        exp_b_q.push_back(pk_b(1, 4, 16'hFFFD));
        exp_b_q.push_back(pk_b(2, 5, 16'h0007));
        send(16'h0000, 1'b0);
        send(16'h0005, 1'b0);
        send(16'h0000, 1'b0);
        send(16'h0000, 1'b0);
        send(16'hFFFD, 1'b0);
        send(16'h0007, 1'b1);
        check_end(3, 0, 0, 3, 0, 0);

        // Elements offered in IDLE are not accepted, and the count holds
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h0011;
        repeat (3) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("a_nnz_hold_idle", 64'(a_nnz), 64'd3);
        check("b_in_ready_idle", 64'(b_in_ready), 64'd0);

        // All-zero tensor of 8 elements
        do_start();
        for (int k = 0; k < 8; k++) send(16'h0000, k == 7);
        check_end(0, 0, 0, 0, 0, 0);

        // Six non-zero elements: u_a overflows at DEPTH=4
        do_start();
        for (int k = 0; k < 6; k++) begin
            if (k < 4) exp_a_q.push_back(pk_a(k, k, 16'(k + 1)));
            exp_b_q.push_back(pk_b(k, k, 16'(k + 1)));
        end
        for (int k = 0; k < 6; k++) send(16'(k + 1), k == 5);
        check_end(4, 1, 0, 6, 0, 0);

        // Nine ones: u_b runs past the 3-bit index range
        do_start();
        for (int k = 0; k < 9; k++) begin
            if (k < 4) exp_a_q.push_back(pk_a(k, k, 16'h0001));
            if (k < 8) exp_b_q.push_back(pk_b(k, k, 16'h0001));
        end
        for (int k = 0; k < 9; k++) send(16'h0001, k == 8);
        check_end(4, 1, 0, 8, 0, 1);

        // Reset asserted mid-tensor after two writes, then a clean restart
        do_start();
        exp_a_q.push_back(pk_a(0, 0, 16'h0001));
        exp_b_q.push_back(pk_b(0, 0, 16'h0001));
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        check("a_wr_en_pre_rst", 64'(a_wr_en), 64'd1);
        check("a_wr_pre_rst", 64'({a_wr_addr, a_wr_data}), pk_a(1, 1, 16'h0002));
        check("b_wr_pre_rst", 64'({b_wr_addr, b_wr_data}), pk_b(1, 1, 16'h0002));
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        check("a_exp_left_rst", 64'(exp_a_q.size()), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_start();
        exp_a_q.push_back(pk_a(0, 0, 16'h0009));
        exp_b_q.push_back(pk_b(0, 0, 16'h0009));
        send(16'h0009, 1'b1);
        check_end(1, 0, 0, 1, 0, 0);

`ifdef SPARSE_PACK_THRESH_EN
        // Magnitude threshold of 4: stream 3,-4,5,-32768
        thresh = 16'd4;
        do_start();
        exp_a_q.push_back(pk_a(0, 2, 16'h0005));
        exp_a_q.push_back(pk_a(1, 3, 16'h8000));
        exp_b_q.push_back(pk_b(0, 2, 16'h0005));
        exp_b_q.push_back(pk_b(1, 3, 16'h8000));
        send(16'h0003, 1'b0);
        send(16'hFFFC, 1'b0);
        send(16'h0005, 1'b0);
        send(16'h8000, 1'b1);
        check_end(2, 0, 0, 2, 0, 0);
        thresh = 16'd0;
`endif

        // Final report
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
